// File: rtl/fifo_stream_out.sv
// Read-side drain stage for sync_fifo: turns rd_en/empty/rd_data into a valid/ready stream
// via a 2-entry buffer. Optional pop counter enabled by defining FIFO_STREAM_OUT_CNT_EN.
module fifo_stream_out #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic                  busy_o
`ifdef FIFO_STREAM_OUT_CNT_EN
    ,
    output logic [15:0]           xfer_cnt_o
`endif
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t                  occ_q;
    occ_t                  occ_d;
    logic                  inflight_q;
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] last_q;

    logic                  pop;
    logic                  capture;
    logic [1:0]            occ_bits;
    logic [1:0]            cap;

    // cap is the occupancy after this edge; a read issued now lands one edge later
    always_comb begin
        occ_bits     = occ_q;
        pop          = m_valid_o & m_ready_i;
        cap          = occ_bits + {1'b0, inflight_q} - {1'b0, pop};
        fifo_rd_en_o = !fifo_empty_i && !flush_i && (cap < 2'd2);
        capture      = inflight_q & !flush_i;
        occ_d        = OCC_EMPTY;
        if (!flush_i) begin
            case (cap)
                2'd0:    occ_d = OCC_EMPTY;
                2'd1:    occ_d = OCC_ONE;
                default: occ_d = OCC_TWO;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en_o;
        end
    end

    // A flush drops both the buffered words and the word returning this edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            last_q   <= '0;
        end else begin
            if (occ_q != OCC_EMPTY) begin
                last_q <= buf_q[rd_ptr_q];
            end
            if (flush_i) begin
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                if (capture) begin
                    buf_q[wr_ptr_q] <= fifo_rd_data_i;
                    wr_ptr_q        <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
            end
        end
    end

    // When drained, the data bus keeps showing the last word that was presented
    assign m_valid_o = (occ_q != OCC_EMPTY);
    assign m_data_o  = m_valid_o ? buf_q[rd_ptr_q] : last_q;
    assign busy_o    = m_valid_o | inflight_q;

`ifdef FIFO_STREAM_OUT_CNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xfer_cnt_q <= '0;
        end else if (flush_i) begin
            xfer_cnt_q <= '0;
        end else if (pop && (xfer_cnt_q != 16'hFFFF)) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_cnt_o = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out with a behavioural sync_fifo model and stream scoreboard.
// Define FIFO_STREAM_OUT_CNT_EN to also exercise the pop counter.
module tb_fifo_stream_out;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic       busy;
`ifdef FIFO_STREAM_OUT_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    logic       wr_en;
    logic [7:0] wr_data;

    logic [7:0] fq [$];
    int         fcount;
    int         fnext;
    int         reads_issued;
    logic       underflow;

    logic [7:0] recv [$];
    logic       overflow_seen;

    logic [7:0] exp_q [$];
    int         check_count;
    int         fail_count;

    fifo_stream_out #(.DATA_WIDTH(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .fifo_rd_en_o   (fifo_rd_en),
        .fifo_rd_data_i (fifo_rd_data),
        .fifo_empty_i   (fifo_empty),
        .m_valid_o      (m_valid),
        .m_data_o       (m_data),
        .m_ready_i      (m_ready),
        .busy_o         (busy)
`ifdef FIFO_STREAM_OUT_CNT_EN
        ,
        .xfer_cnt_o     (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sync_fifo: registered read data, combinational empty, sticky underflow
    assign fifo_empty = (fcount == 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fcount       <= 0;
            fifo_rd_data <= 8'h00;
            underflow    <= 1'b0;
            reads_issued  = 0;
        end else begin
            fnext = fcount;
            if (fifo_rd_en) begin
                if (fcount == 0) begin
                    underflow <= 1'b1;
                end else begin
                    fifo_rd_data <= fq.pop_front();
                    fnext         = fnext - 1;
                    reads_issued  = reads_issued + 1;
                end
            end
            if (wr_en) begin
                fq.push_back(wr_data);
                fnext = fnext + 1;
            end
            fcount <= fnext;
        end
    end

    // Stream monitor: records every accepted word and flags buffer overcommit
    initial overflow_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) recv.push_back(m_data);
            if (int'(dut.occ_q) + int'(dut.inflight_q) > 2) overflow_seen = 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count = check_count + 1;
        if (observed !== expected) begin
            fail_count = fail_count + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rdy, input logic fl);
        wr_en   = wr;
        wr_data = d;
        m_ready = rdy;
        flush   = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int base;
    int vrun;
    int vmax;
    int rbase;
    logic [7:0] seq;

    initial begin
        check_count = 0;
        fail_count  = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkOutput("rst_valid", 32'(m_valid), 0);
        checkOutput("rst_data", 32'(m_data), 0);
        checkOutput("rst_rden", 32'(fifo_rd_en), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle with an empty FIFO
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("idle_valid", 32'(m_valid), 0);
            checkOutput("idle_rden", 32'(fifo_rd_en), 0);
            checkOutput("idle_busy", 32'(busy), 0);
        end
        checkOutput("idle_underflow", 32'(underflow), 0);

        // 16 words streamed with ready held high
        $display("[TB] streaming 16 words");
        base = recv.size();
        vrun = 0;
        vmax = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 1'b1, 1'b0);
            tick();
            if (i == 0) begin
                checkOutput("lat_rden_n", 32'(fifo_rd_en), 1);
                checkOutput("lat_valid_n", 32'(m_valid), 0);
            end else if (i == 1) begin
                checkOutput("lat_valid_n1", 32'(m_valid), 0);
            end else begin
                checkOutput("stream_valid", 32'(m_valid), 1);
                checkOutput("stream_data", 32'(m_data), 32'(i - 1));
            end
            vrun = m_valid ? vrun + 1 : 0;
            if (vrun > vmax) vmax = vrun;
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            vrun = m_valid ? vrun + 1 : 0;
            if (vrun > vmax) vmax = vrun;
        end
        checkOutput("stream_run", 32'(vmax), 16);
        checkOutput("stream_count", 32'(recv.size() - base), 16);
        for (int i = 0; i < 16; i++) begin
            if (base + i < recv.size()) checkOutput("stream_order", 32'(recv[base + i]), 32'(i + 1));
        end
        checkOutput("stream_rden_end", 32'(fifo_rd_en), 0);
        checkOutput("stream_busy_end", 32'(busy), 0);
        checkOutput("stream_underflow", 32'(underflow), 0);

        // Backpressure: only two reads while ready is low
        $display("[TB] backpressure");
        base  = recv.size();
        rbase = reads_issued;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("bp_reads", 32'(reads_issued - rbase), 2);
        checkOutput("bp_fifo_left", 32'(fcount), 3);
        checkOutput("bp_valid", 32'(m_valid), 1);
        checkOutput("bp_data", 32'(m_data), 32'h21);
        checkOutput("bp_rden", 32'(fifo_rd_en), 0);
        repeat (2) tick();
        checkOutput("bp_data_hold", 32'(m_data), 32'h21);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (12) tick();
        checkOutput("bp_count", 32'(recv.size() - base), 5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < recv.size()) checkOutput("bp_order", 32'(recv[base + i]), 32'(8'h21 + i));
        end

        // Random writes and ready toggling against a scoreboard
        $display("[TB] random traffic");
        base = recv.size();
        exp_q.delete();
        seq = 8'h80;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus(1'b1, seq, 1'($urandom_range(0, 1)), 1'b0);
                exp_q.push_back(seq);
                seq = seq + 8'd1;
            end else begin
                applyStimulus(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
            end
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (recv.size() - base >= exp_q.size() && !busy) break;
            tick();
        end
        checkOutput("rand_count", 32'(recv.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < recv.size()) checkOutput("rand_order", 32'(recv[base + i]), 32'(exp_q[i]));
        end
        checkOutput("rand_overflow", 32'(overflow_seen), 0);
        checkOutput("rand_underflow", 32'(underflow), 0);

        // Flush with word 0x43 in flight and 0x42 buffered
        $display("[TB] flush");
        base = recv.size();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'h41 + i), 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("fl_fifo_left", 32'(fcount), 2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        #1;
        checkOutput("fl_pop_rden", 32'(fifo_rd_en), 1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        checkOutput("fl_rden_during", 32'(fifo_rd_en), 0);
        checkOutput("fl_busy_before", 32'(busy), 1);
        tick();
        checkOutput("fl_valid_after", 32'(m_valid), 0);
        checkOutput("fl_busy_after", 32'(busy), 0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (8) tick();
        checkOutput("fl_count", 32'(recv.size() - base), 2);
        if (recv.size() - base >= 2) begin
            checkOutput("fl_first", 32'(recv[base]), 32'h41);
            checkOutput("fl_next", 32'(recv[base + 1]), 32'h44);
        end
        checkOutput("fl_fifo_empty", 32'(fcount), 0);

`ifdef FIFO_STREAM_OUT_CNT_EN
        // Pop counter: clear, count 10 transfers, clear again
        $display("[TB] transfer counter");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        checkOutput("cnt_clear0", 32'(xfer_cnt), 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (6) tick();
        checkOutput("cnt_ten", 32'(xfer_cnt), 10);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("cnt_flush", 32'(xfer_cnt), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/fifo_stream_out.md
Name: fifo_stream_out

Overview:
Read-side drain stage that sits directly downstream of sync_fifo. It drives the FIFO's rd_en/empty/rd_data interface and presents the words as a valid/ready stream. A 2-entry output buffer absorbs the FIFO's 1-cycle read latency, so the block sustains 1 word/cycle under continuous m_ready_i. It never reads an empty FIFO, so the FIFO's underflow_o can never be raised by this block.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  synchronous discard of buffered and in-flight words
fifo_rd_en_o  out  1  read strobe to sync_fifo rd_en_i
fifo_rd_data_i  in  DATA_WIDTH  sync_fifo rd_data_o
fifo_empty_i  in  1  sync_fifo empty_o
m_valid_o  out  1  stream word available
m_data_o  out  DATA_WIDTH  stream data (head of buffer)
m_ready_i  in  1  downstream accepts word
busy_o  out  1  buffer non-empty or read in flight

Behaviour:
- Reset (async, active-high): buffer cleared, rd/wr pointers 0, occupancy 0, in-flight flag 0. Outputs: m_valid_o=0, m_data_o=0, fifo_rd_en_o=0, busy_o=0. Any in-flight word is dropped; sync_fifo is reset by the same rst_i.
- FIFO read timing: a read issued at edge E (fifo_rd_en_o=1 and fifo_empty_i=0) presents its word on fifo_rd_data_i during the cycle after E. The block captures that word at edge E+1.
- Occupancy state: EMPTY(0), ONE(1), TWO(2). Define pop = m_valid_o & m_ready_i and cap = inflight + occ - pop.
- fifo_rd_en_o = !fifo_empty_i & !flush_i & (cap < 2). It is combinational from state, fifo_empty_i, m_ready_i and flush_i.
- Transitions at each edge: occ_next = occ + inflight - pop. inflight_next = fifo_rd_en_o. A capture writes the buffer at wr_ptr, and a pop advances rd_ptr. Both pointers are 1 bit and wrap 1->0.
- Simultaneous capture and pop in state ONE or TWO: occupancy is unchanged, and the data order is preserved.
- Occupancy never exceeds 2. An overflow of the 2-entry buffer is a design error; the bench asserts it never occurs.
- m_valid_o = (occ != 0). m_data_o = buffer[rd_ptr], and it holds stable while m_valid_o=1 & m_ready_i=0. When occ=0, m_data_o holds its last value (0 after reset).
- Latency: FIFO becomes non-empty at edge N (fifo_rd_en_o goes high in that cycle) -> m_valid_o rises after edge N+2.
- Throughput: with m_ready_i held at 1 and the FIFO never empty, one word is transferred per cycle after the initial 2-cycle fill.
- Backpressure with m_ready_i=0: reads stop once occ + inflight = 2. fifo_rd_en_o stays 0 until a pop occurs.
- flush_i=1 at edge E:
  - occ, pointers and inflight are cleared.
  - The word returning from a read issued at E-1 is discarded.
  - fifo_rd_en_o=0 during the flush cycle.
  - m_valid_o=0 after E.
  - A pop in the same cycle as flush is still counted as accepted by downstream.
- busy_o = (occ != 0) | inflight.
- Ordering: words leave in exactly the order they were read from the FIFO. No word is duplicated or lost except by flush_i or rst_i.

Optional Feature:
Macro: FIFO_STREAM_OUT_CNT_EN.
- Defined: adds output xfer_cnt_o [15:0], which counts pops.
  - Reset value 0.
  - Saturates at 16'hFFFF.
  - Cleared by flush_i, and the clear takes priority over an increment in the same cycle.
- Undefined: the port and counter do not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset then idle with fifo_empty_i=1 -> m_valid_o=0, fifo_rd_en_o=0, busy_o=0 for 20 cycles. sync_fifo underflow_o stays 0.
- Write 16 words (0x01..0x10) into sync_fifo, hold m_ready_i=1 -> output 0x01..0x10 in order, 16 consecutive valid cycles after the 2-cycle fill. fifo_rd_en_o deasserts once empty_o=1, and underflow_o stays 0.
- Write 5 words, hold m_ready_i=0 -> exactly 2 reads issued, m_data_o=first word held stable, FIFO keeps 3. Then release m_ready_i -> all 5 words emerge in order.
- Continuous writes with m_ready_i toggling randomly for 200 cycles (scoreboard) -> all written words received exactly once in order. Buffer occupancy never exceeds 2.
- Write 4 words, m_ready_i=0, assert flush_i for 1 cycle while a read is in flight -> m_valid_o=0 next cycle, 2 words lost. With m_ready_i=1, the next word out is the 4th word written.
- With FIFO_STREAM_OUT_CNT_EN defined: transfer 10 words -> xfer_cnt_o=10. Pulse flush_i -> xfer_cnt_o=0.
